shr_seq_arbiter: RTL and testbench



---
 rtl/shr_seq_arbiter.sv | 135 +++++++++++++
 tb/tb_shr_seq_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shr_seq_arbiter.sv
// shr_seq_arbiter
//   Shares one iterative shift-right engine between two requesters. A granted
//   request loads its operand and step count. The engine then shifts right by
//   I bits on each enabled cycle until the count runs out. The result is held
//   on OUT_* together with the owning requester ID until the consumer takes it.
//
// Ports
//   CLK, RST        clock; synchronous active-high reset
//   EN              global enable; low freezes every register and blocks handshakes
//   REQx_VALID/READY/DATA/AMT   request channel x (x = 0, 1); READY is combinational
//   OUT_VALID/READY/DATA/ID     result channel
//   BUSY            high whenever the engine is not idle
//
// Build option
//   SHR_SEQ_EARLY_ZERO_EN: when defined, SHIFT ends as soon as the shifted data
//   becomes all-zero. The result is unchanged; only latency differs.
//
// state | meaning
// IDLE  | waiting for a request; grant is issued here
// SHIFT | shifting data right by I per enabled cycle
// DONE  | result presented, waiting for OUT_READY
module shr_seq_arbiter #(
  parameter int N  = 16,
  parameter int I  = 1,
  parameter int CW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          REQ0_VALID,
  output logic          REQ0_READY,
  input  logic [N-1:0]  REQ0_DATA,
  input  logic [CW-1:0] REQ0_AMT,
  input  logic          REQ1_VALID,
  output logic          REQ1_READY,
  input  logic [N-1:0]  REQ1_DATA,
  input  logic [CW-1:0] REQ1_AMT,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [N-1:0]  OUT_DATA,
  output logic          OUT_ID,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          id_q, id_d;
  // ID of the most recently granted requester; resets to 1 so REQ0 wins first.
  logic          last_q, last_d;

  logic          grant0, grant1;
  logic          accept_ok;
  logic [N-1:0]  data_shr;

  always_comb begin
    grant0     = REQ0_VALID & (~REQ1_VALID | last_q);
    grant1     = REQ1_VALID & ~grant0;
    accept_ok  = EN & ~RST & (state_q == S_IDLE);
    REQ0_READY = accept_ok & grant0;
    REQ1_READY = accept_ok & grant1;
    data_shr   = data_q >> I;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;
    if (EN) begin
      case (state_q)
        S_IDLE: begin
          if (REQ0_READY || REQ1_READY) begin
            data_d  = REQ1_READY ? REQ1_DATA : REQ0_DATA;
            cnt_d   = REQ1_READY ? REQ1_AMT : REQ0_AMT;
            id_d    = REQ1_READY;
            last_d  = REQ1_READY;
            state_d = (cnt_d != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          data_d = data_shr;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
          end
`ifdef SHR_SEQ_EARLY_ZERO_EN
          // Further shifts cannot change an all-zero value, so finish early.
          if (data_shr == '0) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
`endif
        end
        S_DONE: begin
          if (OUT_READY) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    OUT_VALID = (state_q == S_DONE);
    OUT_DATA  = data_q;
    OUT_ID    = id_q;
    BUSY      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_shr_seq_arbiter.sv
module tb_shr_seq_arbiter;
  localparam int N  = 16;
  localparam int I  = 1;
  localparam int CW = 5;

  logic          CLK, RST, EN;
  logic          REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [N-1:0]  REQ0_DATA, REQ1_DATA, OUT_DATA;
  logic [CW-1:0] REQ0_AMT, REQ1_AMT;
  logic          OUT_VALID, OUT_READY, OUT_ID, BUSY;

  shr_seq_arbiter #(.N(N), .I(I), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_DATA(REQ0_DATA), .REQ0_AMT(REQ0_AMT),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_DATA(REQ1_DATA), .REQ1_AMT(REQ1_AMT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_ID(OUT_ID),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the result is simply the operand shifted by AMT*I in one go.
  function automatic logic [N-1:0] ref_result(input logic [N-1:0] d, input int amt);
    if (amt * I >= N) return '0;
    return d >> (amt * I);
  endfunction

  // Number of enabled SHIFT cycles the engine should spend on a request.
  function automatic int ref_shifts(input logic [N-1:0] d, input int amt);
`ifdef SHR_SEQ_EARLY_ZERO_EN
    int bl;
    int z;
    bl = 0;
    for (int b = 0; b < N; b++) if (d[b]) bl = b + 1;
    z = (bl + I - 1) / I;
    if (z < 1) z = 1;
    return (amt < z) ? amt : z;
`else
    return amt;
`endif
  endfunction

  typedef struct {
    logic [N-1:0] data;
    logic         id;
    int           due;
  } exp_t;

  exp_t sbq[$];
  logic inflight = 1'b0;
  logic last_id  = 1'b1;
  int   en_cnt   = 0;

  // Monitor / scoreboard: predicts grants, pushes expected results on accept,
  // pops and compares when the DUT presents a result.
  always @(negedge CLK) begin
    logic g0, g1, exp_valid;
    exp_t e;
    if (RST) begin
      chk("ready_in_reset", {30'd0, REQ0_READY, REQ1_READY}, 32'd0);
      inflight = 1'b0;
      last_id  = 1'b1;
      sbq.delete();
    end else begin
      chk("busy", {31'd0, BUSY}, {31'd0, inflight});
      g0 = 1'b0;
      g1 = 1'b0;
      if (EN && !inflight) begin
        g0 = REQ0_VALID && (!REQ1_VALID || last_id);
        g1 = REQ1_VALID && !g0;
      end
      chk("ready", {30'd0, REQ0_READY, REQ1_READY}, {30'd0, g0, g1});
      exp_valid = inflight && (sbq.size() > 0) && (en_cnt >= sbq[0].due);
      chk("out_valid", {31'd0, OUT_VALID}, {31'd0, exp_valid});
      if (OUT_VALID && sbq.size() > 0) begin
        chk("out_data", {16'd0, OUT_DATA}, {16'd0, sbq[0].data});
        chk("out_id", {31'd0, OUT_ID}, {31'd0, sbq[0].id});
        if (OUT_READY && EN) begin
          void'(sbq.pop_front());
          inflight = 1'b0;
        end
      end
      if (g0 || g1) begin
        e.id   = g1;
        e.data = g1 ? ref_result(REQ1_DATA, int'(REQ1_AMT)) : ref_result(REQ0_DATA, int'(REQ0_AMT));
        e.due  = en_cnt + 1 + (g1 ? ref_shifts(REQ1_DATA, int'(REQ1_AMT))
                                  : ref_shifts(REQ0_DATA, int'(REQ0_AMT)));
        sbq.push_back(e);
        last_id  = g1;
        inflight = 1'b1;
      end
      if (EN) en_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present requests and hold each until it is accepted.
  task automatic serve(input logic v0, input logic [N-1:0] d0, input logic [CW-1:0] a0,
                       input logic v1, input logic [N-1:0] d1, input logic [CW-1:0] a1);
    logic acc0, acc1;
    REQ0_VALID = v0; REQ0_DATA = d0; REQ0_AMT = a0;
    REQ1_VALID = v1; REQ1_DATA = d1; REQ1_AMT = a1;
    for (int k = 0; k < 300 && (REQ0_VALID || REQ1_VALID); k++) begin
      @(negedge CLK);
      acc0 = REQ0_VALID && REQ0_READY;
      acc1 = REQ1_VALID && REQ1_READY;
      tick();
      if (acc0) REQ0_VALID = 1'b0;
      if (acc1) REQ1_VALID = 1'b0;
    end
    chk("serve_timeout", {30'd0, REQ0_VALID, REQ1_VALID}, 32'd0);
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge CLK);
      if (!BUSY && !OUT_VALID) done = 1'b1;
      else tick();
    end
    chk("idle_timeout", {31'd0, done}, 32'd1);
    tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_data", {16'd0, OUT_DATA}, 32'd0);
    chk("rst_out_id", {31'd0, OUT_ID}, 32'd0);
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a0, a1;
    logic got_valid;
    RST = 1'b1; EN = 1'b1; OUT_READY = 1'b1;
    REQ0_VALID = 1'b0; REQ0_DATA = '0; REQ0_AMT = '0;
    REQ1_VALID = 1'b0; REQ1_DATA = '0; REQ1_AMT = '0;
    do_reset();

    // Basic shift, then contention order after reset.
    serve(1'b1, 16'hF0F0, 5'd4, 1'b0, '0, '0);
    wait_idle();
    do_reset();
    serve(1'b1, 16'h1111, 5'd1, 1'b1, 16'h2222, 5'd1);
    wait_idle();
    serve(1'b1, 16'h3333, 5'd1, 1'b1, 16'h4444, 5'd1);
    wait_idle();

    // Zero step count and over-range step count.
    serve(1'b0, '0, '0, 1'b1, 16'hABCD, 5'd0);
    wait_idle();
    serve(1'b0, '0, '0, 1'b1, 16'h1234, 5'd20);
    wait_idle();

    // Consumer back-pressure while a competing request waits.
    OUT_READY = 1'b0;
    serve(1'b1, 16'h00FF, 5'd2, 1'b0, '0, '0);
    REQ1_VALID = 1'b1; REQ1_DATA = 16'h5A5A; REQ1_AMT = 5'd3;
    got_valid = 1'b0;
    for (int k = 0; k < 50 && !got_valid; k++) begin
      @(negedge CLK);
      got_valid = OUT_VALID;
      tick();
    end
    chk("backpressure_valid_seen", {31'd0, got_valid}, 32'd1);
    tick(); tick();
    OUT_READY = 1'b1;
    serve(1'b0, '0, '0, 1'b1, 16'h5A5A, 5'd3);
    wait_idle();

    // EN low for two cycles in the middle of SHIFT.
    serve(1'b1, 16'h8000, 5'd3, 1'b0, '0, '0);
    tick();
    EN = 1'b0;
    tick(); tick();
    EN = 1'b1;
    wait_idle();

    // Reset in the middle of SHIFT discards the operation.
    serve(1'b1, 16'hFFFF, 5'd10, 1'b0, '0, '0);
    tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_busy", {31'd0, BUSY}, 32'd0);
    chk("midrst_data", {16'd0, OUT_DATA}, 32'd0);
    for (int k = 0; k < 15; k++) tick();

    // Early completion on a value that runs out of set bits.
    serve(1'b1, 16'h0002, 5'd10, 1'b0, '0, '0);
    wait_idle();
    serve(1'b0, '0, '0, 1'b1, 16'h0000, 5'd7);
    wait_idle();

    // Randomized traffic: sources hold VALID/DATA until accepted.
    for (int c = 0; c < 2500; c++) begin
      @(negedge CLK);
      a0 = REQ0_VALID && REQ0_READY;
      a1 = REQ1_VALID && REQ1_READY;
      tick();
      if (!REQ0_VALID || a0) begin
        REQ0_VALID = ($urandom % 3) != 0;
        REQ0_DATA  = N'($urandom);
        REQ0_AMT   = CW'($urandom);
      end
      if (!REQ1_VALID || a1) begin
        REQ1_VALID = ($urandom % 3) != 0;
        REQ1_DATA  = N'($urandom);
        REQ1_AMT   = CW'($urandom);
      end
      EN        = ($urandom % 8) != 0;
      OUT_READY = ($urandom % 3) != 0;
      RST       = ($urandom % 400) == 0;
    end
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    RST = 1'b0; EN = 1'b1; OUT_READY = 1'b1;
    wait_idle();
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
